// File: rtl/input_debouncer_if.sv
// Pin-side bundle of the input debouncer: raw pin levels in, debounced levels
// and per-bit change strobes out.
interface input_debouncer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] clean_out;
  logic [WIDTH-1:0] changed;
  logic             changed_any;

  modport master (
    output raw_in,
    input  clean_out,
    input  changed,
    input  changed_any
  );

  modport slave (
    input  raw_in,
    output clean_out,
    output changed,
    output changed_any
  );
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus per-bit stability counter; a bit's clean level
// follows the synchronised pin only after STABLE_CYCLES consecutive mismatches.
module input_debouncer #(
  parameter int               WIDTH         = 8,
  parameter int               STABLE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] RESET_VALUE   = 8'h0F
) (
  input  logic              clk,
  input  logic              reset,
  input_debouncer_if.slave  bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            sync1_q, sync1_d;
  logic [WIDTH-1:0]            sync2_q, sync2_d;
  logic [WIDTH-1:0]            clean_q, clean_d;
  logic [WIDTH-1:0]            changed_q, changed_d;
  logic                        changed_any_q, changed_any_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: synchroniser shift and per-bit stability counting.
  always_comb begin
    sync1_d   = bus.raw_in;
    sync2_d   = sync1_q;
    clean_d   = clean_q;
    cnt_d     = cnt_q;
    changed_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i]   = sync2_q[i];
        cnt_d[i]     = '0;
        changed_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    changed_any_d = |changed_d;
  end

  // State registers; reset discards any in-flight count without strobing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= RESET_VALUE;
      sync2_q       <= RESET_VALUE;
      clean_q       <= RESET_VALUE;
      cnt_q         <= '0;
      changed_q     <= '0;
      changed_any_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      clean_q       <= clean_d;
      cnt_q         <= cnt_d;
      changed_q     <= changed_d;
      changed_any_q <= changed_any_d;
    end
  end

  assign bus.clean_out   = clean_q;
  assign bus.changed     = changed_q;
  assign bus.changed_any = changed_any_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer (STABLE_CYCLES=4), with a
// second instance at STABLE_CYCLES=1 sharing the same pins.
module tb_input_debouncer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  input_debouncer_if #(.WIDTH(8)) bus ();
  input_debouncer_if #(.WIDTH(8)) bus1 ();

  assign bus1.raw_in = bus.raw_in;

  input_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .RESET_VALUE(8'h0F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  input_debouncer #(.WIDTH(8), .STABLE_CYCLES(1), .RESET_VALUE(8'h0F)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bus.raw_in = 8'h0F;
    tick();
    tick();
    n_checks = n_checks + 1;
    if (bus.clean_out !== 8'h0F) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_hold clean_out got %h exp %h", bus.clean_out, 8'h0F);
    end
    reset = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      n_checks = n_checks + 1;
      if (bus.clean_out !== 8'h0F || bus.changed !== 8'h00 || bus.changed_any !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_idle e=%0d clean=%h changed=%h any=%b exp 0f/00/0",
                 e, bus.clean_out, bus.changed, bus.changed_any);
      end
    end
  endtask

  task automatic test_clean_edge();
    logic [7:0] exp_clean;
    logic [7:0] exp_chg;
    logic [7:0] exp_clean1;
    logic [7:0] exp_chg1;
    bus.raw_in = 8'h1F;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_clean  = (e >= 6) ? 8'h1F : 8'h0F;
      exp_chg    = (e == 6) ? 8'h10 : 8'h00;
      exp_clean1 = (e >= 3) ? 8'h1F : 8'h0F;
      exp_chg1   = (e == 3) ? 8'h10 : 8'h00;
      n_checks = n_checks + 1;
      if (bus.clean_out !== exp_clean) begin
        n_fail = n_fail + 1;
        $display("FAIL clean_edge clean_out e=%0d got %h exp %h", e, bus.clean_out, exp_clean);
      end
      n_checks = n_checks + 1;
      if (bus.changed !== exp_chg || bus.changed_any !== (e == 6)) begin
        n_fail = n_fail + 1;
        $display("FAIL clean_edge changed e=%0d got %h/%b exp %h/%b",
                 e, bus.changed, bus.changed_any, exp_chg, (e == 6));
      end
      n_checks = n_checks + 1;
      if (bus1.clean_out !== exp_clean1 || bus1.changed !== exp_chg1) begin
        n_fail = n_fail + 1;
        $display("FAIL stable1_edge e=%0d got %h/%h exp %h/%h",
                 e, bus1.clean_out, bus1.changed, exp_clean1, exp_chg1);
      end
    end
    bus.raw_in = 8'h0F;
    for (int e = 1; e <= 8; e++) tick();
    n_checks = n_checks + 1;
    if (bus.clean_out !== 8'h0F || bus.changed !== 8'h00) begin
      n_fail = n_fail + 1;
      $display("FAIL clean_edge_return got %h/%h exp 0f/00", bus.clean_out, bus.changed);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_clean;
    logic [7:0] exp_chg;
    int         strobes;
    strobes = 0;
    for (int e = 1; e <= 12; e++) begin
      bus.raw_in = (e == 1 || e == 3) ? 8'h0F : 8'h0D;
      tick();
      if (bus.changed[1] === 1'b1) strobes = strobes + 1;
      exp_clean = (e >= 9) ? 8'h0D : 8'h0F;
      exp_chg   = (e == 9) ? 8'h02 : 8'h00;
      n_checks = n_checks + 1;
      if (bus.clean_out !== exp_clean || bus.changed !== exp_chg) begin
        n_fail = n_fail + 1;
        $display("FAIL bounce e=%0d got %h/%h exp %h/%h",
                 e, bus.clean_out, bus.changed, exp_clean, exp_chg);
      end
    end
    n_checks = n_checks + 1;
    if (strobes != 1) begin
      n_fail = n_fail + 1;
      $display("FAIL bounce_strobes got %0d exp 1", strobes);
    end
    bus.raw_in = 8'h0F;
    for (int e = 1; e <= 8; e++) tick();
    n_checks = n_checks + 1;
    if (bus.clean_out !== 8'h0F) begin
      n_fail = n_fail + 1;
      $display("FAIL bounce_return got %h exp 0f", bus.clean_out);
    end
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 12; e++) begin
      bus.raw_in = (e <= 3) ? 8'h0E : 8'h0F;
      tick();
      n_checks = n_checks + 1;
      if (bus.clean_out !== 8'h0F || bus.changed !== 8'h00 || bus.changed_any !== 1'b0) begin
        n_fail = n_fail + 1;
        $display("FAIL glitch e=%0d got %h/%h/%b exp 0f/00/0",
                 e, bus.clean_out, bus.changed, bus.changed_any);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp_clean;
    logic [7:0] exp_chg;
    bus.raw_in = 8'hF0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_clean = (e >= 6) ? 8'hF0 : 8'h0F;
      exp_chg   = (e == 6) ? 8'hFF : 8'h00;
      n_checks = n_checks + 1;
      if (bus.clean_out !== exp_clean || bus.changed !== exp_chg || bus.changed_any !== (e == 6)) begin
        n_fail = n_fail + 1;
        $display("FAIL simultaneous e=%0d got %h/%h/%b exp %h/%h/%b",
                 e, bus.clean_out, bus.changed, bus.changed_any, exp_clean, exp_chg, (e == 6));
      end
    end
    bus.raw_in = 8'h0F;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_clean = (e >= 6) ? 8'h0F : 8'hF0;
      exp_chg   = (e == 6) ? 8'hFF : 8'h00;
      n_checks = n_checks + 1;
      if (bus.clean_out !== exp_clean || bus.changed !== exp_chg) begin
        n_fail = n_fail + 1;
        $display("FAIL simultaneous_back e=%0d got %h/%h exp %h/%h",
                 e, bus.clean_out, bus.changed, exp_clean, exp_chg);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_clean;
    logic [7:0] exp_chg;
    bus.raw_in = 8'h1F;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_checks = n_checks + 1;
    if (bus.clean_out !== 8'h0F || bus.changed !== 8'h00 || bus.changed_any !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_mid_entry got %h/%h/%b exp 0f/00/0",
               bus.clean_out, bus.changed, bus.changed_any);
    end
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_clean = (e >= 6) ? 8'h1F : 8'h0F;
      exp_chg   = (e == 6) ? 8'h10 : 8'h00;
      n_checks = n_checks + 1;
      if (bus.clean_out !== exp_clean || bus.changed !== exp_chg) begin
        n_fail = n_fail + 1;
        $display("FAIL reset_mid e=%0d got %h/%h exp %h/%h",
                 e, bus.clean_out, bus.changed, exp_clean, exp_chg);
      end
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.raw_in = 8'h0F;
    test_reset();
    test_clean_edge();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
